// File: rtl/solar_tracker_ctrl_if.sv
// Sensor/threshold inputs and motor/status outputs of the solar tracker.
interface solar_tracker_ctrl_if #(
  parameter int DW = 8,
  parameter int TW = 16
);
  logic          en;
  logic [DW-1:0] th;
  logic [TW-1:0] timeout;
  logic [DW-1:0] lsn;
  logic [DW-1:0] lse;
  logic [DW-1:0] lss;
  logic [DW-1:0] lsw;
  logic          mn;
  logic          me;
  logic          ms;
  logic          mw;
  logic          busy;
  logic          fault;

  modport master (
    output en, th, timeout, lsn, lse, lss, lsw,
    input  mn, me, ms, mw, busy, fault
  );

  modport slave (
    input  en, th, timeout, lsn, lse, lss, lsw,
    output mn, me, ms, mw, busy, fault
  );
endinterface

// File: rtl/solar_tracker_ctrl.sv
// Two-axis sun-tracking motor controller with settle window, hysteresis stop and motion timeout.
// Optional macro SOLAR_AUTO_RETRY_EN: leave FAULT automatically after RETRY_CYCLES edges.
//
// state  | meaning
// IDLE   | motors off, waiting for a winning request
// SETTLE | request must stay the same winner for SETTLE more edges
// MOVE   | one motor enabled until stop, !en or timeout
// FAULT  | motion timed out; motors off until en==0 (or retry expiry)
module solar_tracker_ctrl #(
  parameter int DW           = 8,
  parameter int TW           = 16,
  parameter int SETTLE       = 4,
  parameter int RETRY_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 rst,
  solar_tracker_ctrl_if.slave bus
);

  localparam int CW = $clog2(SETTLE + 1);

  if (SETTLE < 1 || RETRY_CYCLES < 1) begin : g_bad_param
    $error("solar_tracker_ctrl: SETTLE and RETRY_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETTLE_ST, MOVE, FAULT} state_t;
  typedef enum logic [1:0] {DIR_N, DIR_S, DIR_E, DIR_W} dir_t;

  state_t        state, state_d;
  dir_t          dir, dir_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [TW-1:0] tmr, tmr_d;

  // Sums are one bit wider than the sensors so a large level plus threshold never wraps.
  logic [DW:0] lim_n, lim_s, lim_e, lim_w;
  logic        req_n, req_s, req_e, req_w;
  logic        has_win;
  dir_t        win;
  logic        stop;
  logic        tmo_hit;

  assign lim_n = {1'b0, bus.lss} + {1'b0, bus.th};
  assign lim_s = {1'b0, bus.lsn} + {1'b0, bus.th};
  assign lim_e = {1'b0, bus.lsw} + {1'b0, bus.th};
  assign lim_w = {1'b0, bus.lse} + {1'b0, bus.th};

  assign req_n = {1'b0, bus.lsn} > lim_n;
  assign req_s = {1'b0, bus.lss} > lim_s;
  assign req_e = {1'b0, bus.lse} > lim_e;
  assign req_w = {1'b0, bus.lsw} > lim_w;

  always_comb begin
    has_win = 1'b1;
    win     = DIR_N;
    if (req_n)      win = DIR_N;
    else if (req_s) win = DIR_S;
    else if (req_e) win = DIR_E;
    else if (req_w) win = DIR_W;
    else            has_win = 1'b0;
  end

  always_comb begin
    stop = 1'b0;
    case (dir)
      DIR_N: stop = bus.lsn <= bus.lss;
      DIR_S: stop = bus.lss <= bus.lsn;
      DIR_E: stop = bus.lse <= bus.lsw;
      DIR_W: stop = bus.lsw <= bus.lse;
      default: stop = 1'b1;
    endcase
  end

  assign tmo_hit = (bus.timeout != '0) && (tmr == bus.timeout - TW'(1));

`ifdef SOLAR_AUTO_RETRY_EN
  localparam int RW = $clog2(RETRY_CYCLES + 1);
  logic [RW-1:0] retry, retry_d;
  logic          retry_done;
  assign retry_done = (retry == RW'(RETRY_CYCLES - 1));
`endif

  always_comb begin
    state_d = state;
    dir_d   = dir;
    cnt_d   = cnt;
    tmr_d   = tmr;
`ifdef SOLAR_AUTO_RETRY_EN
    retry_d = retry;
`endif
    case (state)
      IDLE: begin
        if (bus.en && has_win) begin
          dir_d   = win;
          cnt_d   = CW'(1);
          state_d = SETTLE_ST;
        end
      end
      SETTLE_ST: begin
        if (!bus.en || !has_win || win != dir) begin
          state_d = IDLE;
        end else if (cnt == CW'(SETTLE)) begin
          state_d = MOVE;
          tmr_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      MOVE: begin
        if (!bus.en || stop) begin
          state_d = IDLE;
        end else if (tmo_hit) begin
          state_d = FAULT;
`ifdef SOLAR_AUTO_RETRY_EN
          retry_d = '0;
`endif
        end else if (tmr != '1) begin
          tmr_d = tmr + TW'(1);
        end
      end
      FAULT: begin
        if (!bus.en) begin
          state_d = IDLE;
        end
`ifdef SOLAR_AUTO_RETRY_EN
        else if (retry_done) begin
          state_d = IDLE;
        end else begin
          retry_d = retry + RW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dir   <= DIR_N;
      cnt   <= '0;
      tmr   <= '0;
`ifdef SOLAR_AUTO_RETRY_EN
      retry <= '0;
`endif
    end else begin
      state <= state_d;
      dir   <= dir_d;
      cnt   <= cnt_d;
      tmr   <= tmr_d;
`ifdef SOLAR_AUTO_RETRY_EN
      retry <= retry_d;
`endif
    end
  end

  assign bus.mn    = (state == MOVE) && (dir == DIR_N);
  assign bus.ms    = (state == MOVE) && (dir == DIR_S);
  assign bus.me    = (state == MOVE) && (dir == DIR_E);
  assign bus.mw    = (state == MOVE) && (dir == DIR_W);
  assign bus.busy  = (state == SETTLE_ST) || (state == MOVE);
  assign bus.fault = (state == FAULT);

endmodule

// File: tb/tb_solar_tracker_ctrl.sv
// Directed bench for solar_tracker_ctrl; expected {mn,me,ms,mw,busy,fault} queued per edge.
module tb_solar_tracker_ctrl;

  localparam int DW    = 8;
  localparam int TW    = 16;
  localparam int SETL  = 4;
  localparam int RETRY = 16;

  localparam logic [5:0] OFF  = 6'b000000;
  localparam logic [5:0] BUSY = 6'b000010;
  localparam logic [5:0] MN   = 6'b100010;
  localparam logic [5:0] MS   = 6'b001010;
  localparam logic [5:0] MW   = 6'b000110;
  localparam logic [5:0] FLT  = 6'b000001;

  logic clk = 1'b0;
  logic rst;

  solar_tracker_ctrl_if #(.DW(DW), .TW(TW)) bus ();

  solar_tracker_ctrl #(
    .DW(DW), .TW(TW), .SETTLE(SETL), .RETRY_CYCLES(RETRY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [5:0] exp_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Queue the expectation for the coming edge, then pop and compare just after it.
  task automatic step(input logic [5:0] exp, input string tag);
    logic [5:0] e;
    logic [5:0] obs;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    obs = {bus.mn, bus.me, bus.ms, bus.mw, bus.busy, bus.fault};
    n_checks++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b (mn me ms mw busy fault)", t, obs, e);
    end
  endtask

  task automatic set_sensors(input int n, input int e, input int s, input int w);
    bus.lsn = DW'(n);
    bus.lse = DW'(e);
    bus.lss = DW'(s);
    bus.lsw = DW'(w);
  endtask

  initial begin
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.th      = DW'(10);
    bus.timeout = '0;
    set_sensors(100, 100, 100, 100);

    step(OFF, "reset_0");
    step(OFF, "reset_1");
    rst    = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 20; i++) step(OFF, "idle_equal");

    // Settle then move north
    bus.lsn = DW'(150);
    for (int i = 0; i < SETL; i++) step(BUSY, "settle_n");
    step(MN, "move_n_start");
    step(MN, "move_n_hold");
    bus.lsn = DW'(100);
    step(OFF, "stop_n");
    step(OFF, "stop_n_idle");

    // East settle aborted by higher-priority north
    set_sensors(100, 200, 100, 50);
    step(BUSY, "settle_e_1");
    step(BUSY, "settle_e_2");
    bus.lsn = DW'(200);
    bus.lss = DW'(50);
    step(OFF, "abort_to_idle");
    for (int i = 0; i < SETL; i++) step(BUSY, "resettle_n");
    step(MN, "prio_move_n");
    set_sensors(100, 100, 100, 100);
    step(OFF, "prio_stop");

    // West motion timeout
    bus.timeout = TW'(8);
    set_sensors(100, 20, 100, 200);
    for (int i = 0; i < SETL; i++) step(BUSY, "settle_w");
    for (int i = 0; i < 8; i++) step(MW, "move_w");
    step(FLT, "timeout_fault");
`ifdef SOLAR_AUTO_RETRY_EN
    for (int i = 0; i < RETRY - 1; i++) step(FLT, "fault_dwell");
    step(OFF, "retry_idle");
    step(BUSY, "retry_resettle");
    bus.en = 1'b0;
    step(OFF, "retry_en_off");
    set_sensors(100, 100, 100, 100);
    bus.en = 1'b1;
    step(OFF, "retry_quiet");
`else
    for (int i = 0; i < 5; i++) step(FLT, "fault_sticky");
    set_sensors(100, 100, 100, 100);
    bus.en = 1'b0;
    step(OFF, "fault_clear_en");
    bus.en = 1'b1;
    step(OFF, "fault_cleared");
`endif

    // Wide-sum overflow: 255 > 250+20 must be false
    bus.timeout = '0;
    bus.th      = DW'(20);
    set_sensors(255, 100, 250, 100);
    for (int i = 0; i < 50; i++) step(OFF, "overflow_no_req");

    // Stop on the last allowed MOVE cycle wins over timeout
    bus.th      = DW'(10);
    bus.timeout = TW'(3);
    set_sensors(50, 100, 200, 100);
    for (int i = 0; i < SETL; i++) step(BUSY, "settle_s");
    for (int i = 0; i < 3; i++) step(MS, "move_s");
    bus.lss = DW'(50);
    step(OFF, "stop_beats_timeout");
    step(OFF, "no_fault_after_stop");

    // Reset while moving south
    bus.timeout = '0;
    bus.lss     = DW'(200);
    for (int i = 0; i < SETL; i++) step(BUSY, "settle_s2");
    step(MS, "move_s2_a");
    step(MS, "move_s2_b");
    rst = 1'b1;
    step(OFF, "reset_mid_move");
    rst = 1'b0;
    bus.lss = DW'(50);
    step(OFF, "after_reset_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
